// File: rtl/piso_if.sv
// ---------------------------------------------------------------------------
// piso_if
//   Load handshake and serial-side signals of the parallel-in/serial-out
//   serializer, bundled so that producer and serializer share one port.
//
//   Signals
//     load_valid   producer offers parallel_in
//     load_ready   serializer can accept a word this cycle
//     parallel_in  WIDTH-bit word, sampled on accept
//     shift_en     bit-rate strobe; consumes the current serial bit
//     serial_out   current serial bit (registered)
//     serial_valid serial_out carries a frame bit
//     frame_start  1-cycle pulse: first bit of a frame is on serial_out
//     frame_done   1-cycle pulse: last bit of a frame is being consumed
//     busy         frame in progress (same as serial_valid)
//
//   Modports
//     master  producer / line driver side (drives load and strobe inputs)
//     slave   serializer side
// ---------------------------------------------------------------------------
interface piso_if #(
  parameter int unsigned WIDTH = 8
) ();

  logic             load_valid;
  logic             load_ready;
  logic [WIDTH-1:0] parallel_in;
  logic             shift_en;
  logic             serial_out;
  logic             serial_valid;
  logic             frame_start;
  logic             frame_done;
  logic             busy;

  modport master (
    output load_valid,
    output parallel_in,
    output shift_en,
    input  load_ready,
    input  serial_out,
    input  serial_valid,
    input  frame_start,
    input  frame_done,
    input  busy
  );

  modport slave (
    input  load_valid,
    input  parallel_in,
    input  shift_en,
    output load_ready,
    output serial_out,
    output serial_valid,
    output frame_start,
    output frame_done,
    output busy
  );

endinterface : piso_if

// File: rtl/piso_serializer.sv
// ---------------------------------------------------------------------------
// piso_serializer
//   Parallel-in/serial-out shifter. A WIDTH-bit word is accepted over a
//   valid/ready handshake and presented one bit per shift_en strobe on a
//   registered serial_out. Back-to-back frames are supported: the next word
//   can be accepted in the same cycle the last bit is consumed, so the line
//   never shows an idle bit between frames.
//
//   Parameters
//     WIDTH       data bits per frame (>= 2)
//     MSB_FIRST   1: bit WIDTH-1 first, 0: bit 0 first
//     IDLE_LEVEL  serial_out level while no frame is active
//
//   Ports
//     clk         rising-edge clock
//     rst_n       asynchronous active-low reset
//     bus         piso_if.slave: load handshake, shift strobe, serial outputs
//
//   Build option
//     PISO_PARITY_EN  when defined, an even-parity bit (^word) follows the
//                     last data bit for one strobe; frame = WIDTH+1 strobes.
//                     When undefined there is no parity state or logic.
// ---------------------------------------------------------------------------
module piso_serializer #(
  parameter int unsigned WIDTH      = 8,
  parameter bit          MSB_FIRST  = 1'b1,
  parameter bit          IDLE_LEVEL = 1'b0
) (
  input  logic   clk,
  input  logic   rst_n,
  piso_if.slave  bus
);

  localparam int unsigned      CNT_W    = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

`ifdef PISO_PARITY_EN
  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_PARITY
  } state_e;
`else
  typedef enum logic {
    S_IDLE,
    S_SHIFT
  } state_e;
`endif

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  state_e             state_q,       state_d;
  logic [WIDTH-1:0]   shreg_q,       shreg_d;
  logic [CNT_W-1:0]   bit_cnt_q,     bit_cnt_d;
  logic               serial_out_q,  serial_out_d;
  logic               frame_start_q, frame_start_d;
`ifdef PISO_PARITY_EN
  logic               parity_q,      parity_d;
`endif

  // -------------------------------------------------------------------------
  // Handshake and frame-end decode
  // -------------------------------------------------------------------------
  logic             last_pending;
  logic             frame_done;
  logic             load_ready;
  logic             accept;
  logic             first_bit;
  logic             next_bit;
  logic [WIDTH-1:0] shreg_shifted;

  // The "last bit" of a frame is the final data bit, or the parity bit when
  // parity is built in. Consuming it ends the frame and opens the load window.
`ifdef PISO_PARITY_EN
  assign last_pending = (state_q == S_PARITY);
`else
  assign last_pending = (state_q == S_SHIFT) && (bit_cnt_q == LAST_IDX);
`endif

  assign frame_done = bus.shift_en & last_pending;
  // Ready in IDLE, or in the very cycle the last bit is consumed so that a
  // new word follows with no gap on the line.
  assign load_ready = (state_q == S_IDLE) | frame_done;
  assign accept     = bus.load_valid & load_ready;

  // shreg_q always holds the bit on serial_out at the outgoing end, so the
  // bit after it is one position further in.
  assign first_bit     = MSB_FIRST ? bus.parallel_in[WIDTH-1] : bus.parallel_in[0];
  assign next_bit      = MSB_FIRST ? shreg_q[WIDTH-2] : shreg_q[1];
  assign shreg_shifted = MSB_FIRST ? {shreg_q[WIDTH-2:0], 1'b0}
                                   : {1'b0, shreg_q[WIDTH-1:1]};

  // -------------------------------------------------------------------------
  // Next-state / datapath
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable gets a default before any branch; a path that
    // leaves one unassigned would infer a latch.
    state_d       = state_q;
    shreg_d       = shreg_q;
    bit_cnt_d     = bit_cnt_q;
    serial_out_d  = serial_out_q;
    frame_start_d = 1'b0;
`ifdef PISO_PARITY_EN
    parity_d      = parity_q;
`endif

    if (accept) begin
      // Accept has priority over frame end: this is the back-to-back reload.
      state_d       = S_SHIFT;
      shreg_d       = bus.parallel_in;
      bit_cnt_d     = '0;
      serial_out_d  = first_bit;
      frame_start_d = 1'b1;
`ifdef PISO_PARITY_EN
      parity_d      = ^bus.parallel_in;
`endif
    end else if (frame_done) begin
      state_d      = S_IDLE;
      serial_out_d = IDLE_LEVEL;
    end else if ((state_q == S_SHIFT) && bus.shift_en) begin
`ifdef PISO_PARITY_EN
      if (bit_cnt_q == LAST_IDX) begin
        state_d      = S_PARITY;
        serial_out_d = parity_q;
        bit_cnt_d    = bit_cnt_q + CNT_ONE;
      end else begin
        shreg_d      = shreg_shifted;
        serial_out_d = next_bit;
        bit_cnt_d    = bit_cnt_q + CNT_ONE;
      end
`else
      // The last data bit is handled by the frame_done branch, so here the
      // counter stays below WIDTH-1 before incrementing and cannot wrap.
      shreg_d      = shreg_shifted;
      serial_out_d = next_bit;
      bit_cnt_d    = bit_cnt_q + CNT_ONE;
`endif
    end
  end

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  // NOTE: the shift register is a handful of flops rather than a memory, so
  // it is reset with everything else; the reset value is observable state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      shreg_q       <= '0;
      bit_cnt_q     <= '0;
      serial_out_q  <= IDLE_LEVEL;
      frame_start_q <= 1'b0;
`ifdef PISO_PARITY_EN
      parity_q      <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every flop samples the values from
      // before this edge, independent of statement order.
      state_q       <= state_d;
      shreg_q       <= shreg_d;
      bit_cnt_q     <= bit_cnt_d;
      serial_out_q  <= serial_out_d;
      frame_start_q <= frame_start_d;
`ifdef PISO_PARITY_EN
      parity_q      <= parity_d;
`endif
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign bus.load_ready   = load_ready;
  assign bus.serial_out   = serial_out_q;
  assign bus.serial_valid = (state_q != S_IDLE);
  assign bus.busy         = (state_q != S_IDLE);
  assign bus.frame_start  = frame_start_q;
  assign bus.frame_done   = frame_done;

  // -------------------------------------------------------------------------
  // Design assertions
  // -------------------------------------------------------------------------
`ifndef SYNTHESIS
  // The bit counter tops out at WIDTH (parity bit) and never wraps.
  a_cnt_range : assert property (@(posedge clk) disable iff (!rst_n)
    bit_cnt_q <= CNT_W'(WIDTH));

  // A frame can only end while one is in progress.
  a_done_busy : assert property (@(posedge clk) disable iff (!rst_n)
    frame_done |-> (state_q != S_IDLE));

  // frame_start always marks a cycle that carries frame bit 0.
  a_start_cnt : assert property (@(posedge clk) disable iff (!rst_n)
    frame_start_q |-> ((state_q == S_SHIFT) && (bit_cnt_q == '0)));
`endif

endmodule : piso_serializer
